// File: rtl/clic_pkg.sv
// clic_pkg: shared types, FSM states and rank compare for the CLIC interrupt arbiter
// Candidate fields are sized for the largest legal configuration (1024 sources,
// 16-bit ctl) so one struct type serves every build; narrower values are zero-extended.
package clic_pkg;
  localparam int DefCtlWidth = 8;
  localparam int MaxIdWidth = 10;
  localparam int MaxCtlWidth = 16;
  typedef struct packed {
    logic                   valid;
    logic [MaxIdWidth-1:0]  id;
    logic [MaxCtlWidth-1:0] ctl;
  } clic_cand_t;
  typedef enum logic [1:0] {IDLE, OFFER, CLEAR, COOL} arb_state_e;
  // a outranks b: valid beats invalid, then higher ctl, then higher id
  function automatic logic rank_gt(input clic_cand_t a, input clic_cand_t b);
    return a.valid && (!b.valid || a.ctl > b.ctl || (a.ctl == b.ctl && a.id > b.id));
  endfunction
endpackage

// File: rtl/clic_max_tree.sv
// clic_max_tree: combinational N-input maximum over ranked interrupt candidates
// Ports: cand_i - N candidates; max_o - highest-ranked candidate (all-zero if none valid).
module clic_max_tree
  import clic_pkg::*;
#(
  parameter int N = 8
) (
  input  clic_cand_t cand_i [N],
  output clic_cand_t max_o
);
  always_comb begin
    max_o = '0;
    for (int i = 0; i < N; i++) max_o = rank_gt(cand_i[i], max_o) ? cand_i[i] : max_o;
  end
endmodule

// File: rtl/clic_irq_arbiter.sv
// clic_irq_arbiter: two-stage pipelined CLIC interrupt arbiter with valid/ready offer and edge pending-clear
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   ip_i, ie_i, edge_i   per-source pending, enable, edge-triggered flag
//   ctl_i                per-source clicintctl, packed {src NrSrc-1 .. src 0}
//   thresh_i             effective threshold; candidates need ctl > thresh_i
//   irq_valid_o/ready_i  offer handshake; irq_id_o/irq_ctl_o held while offered
//   clr_valid_o/clr_id_o one-cycle pending-clear for claimed edge sources
//   shv_i, irq_shv_o     selective hardware vectoring, present only with CLIC_SHV_EN defined
module clic_irq_arbiter
  import clic_pkg::*;
#(
  parameter int NrSrc      = 64,
  parameter int CtlWidth   = DefCtlWidth,
  parameter int GroupSize  = 8,
  parameter int CoolCycles = 2,
  localparam int IdW       = $clog2(NrSrc)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NrSrc-1:0]          ip_i,
  input  logic [NrSrc-1:0]          ie_i,
  input  logic [NrSrc-1:0]          edge_i,
  input  logic [NrSrc*CtlWidth-1:0] ctl_i,
  input  logic [CtlWidth-1:0]       thresh_i,
  output logic                      irq_valid_o,
  input  logic                      irq_ready_i,
  output logic [IdW-1:0]            irq_id_o,
  output logic [CtlWidth-1:0]       irq_ctl_o,
  output logic                      clr_valid_o,
  output logic [IdW-1:0]            clr_id_o
`ifdef CLIC_SHV_EN
  ,
  input  logic [NrSrc-1:0]          shv_i,
  output logic                      irq_shv_o
`endif
);
  localparam int NrGrp = NrSrc / GroupSize;
  localparam int CoolW = $clog2(CoolCycles + 1);
  clic_cand_t s1_d [NrGrp];
  clic_cand_t s1_q [NrGrp];
  clic_cand_t s2_d, s2_q;
  arb_state_e state_q, state_d;
  logic irq_valid_q, irq_valid_d, clr_valid_q, clr_valid_d, shv_q, shv_d;
  logic [IdW-1:0] irq_id_q, irq_id_d, clr_id_q, clr_id_d;
  logic [CtlWidth-1:0] irq_ctl_q, irq_ctl_d;
  logic [CoolW-1:0] cool_q, cool_d;
  logic retract;
  logic unused_s2;
  assign unused_s2 = ^s2_q;
  for (genvar g = 0; g < NrGrp; g++) begin : gen_grp
    clic_cand_t grp [GroupSize];
    for (genvar j = 0; j < GroupSize; j++) begin : gen_src
      localparam int S = g * GroupSize + j;
      assign grp[j] = '{
        valid: ip_i[S] & ie_i[S] & (ctl_i[S*CtlWidth +: CtlWidth] > thresh_i),
        id:    MaxIdWidth'(S),
        ctl:   MaxCtlWidth'(ctl_i[S*CtlWidth +: CtlWidth])
      };
    end
    clic_max_tree #(.N(GroupSize)) u_grp (.cand_i(grp), .max_o(s1_d[g]));
  end
  clic_max_tree #(.N(NrGrp)) u_top (.cand_i(s1_q), .max_o(s2_d));
  // The offer is withdrawn when the latched source stops qualifying, judged on live inputs
  assign retract = !(ip_i[irq_id_q] & ie_i[irq_id_q]) || irq_ctl_q <= thresh_i;
`ifdef CLIC_SHV_EN
  assign irq_shv_o = shv_q;
  assign shv_d = (state_q == IDLE && s2_q.valid) ? shv_i[s2_q.id[IdW-1:0]] : shv_q;
`else
  assign shv_d = 1'b0;
  logic unused_shv;
  assign unused_shv = shv_q;
`endif
  always_comb begin
    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;
    irq_ctl_d   = irq_ctl_q;
    clr_valid_d = 1'b0;
    clr_id_d    = clr_id_q;
    cool_d      = cool_q;
    case (state_q)
      IDLE: if (s2_q.valid) begin
        state_d     = OFFER;
        irq_valid_d = 1'b1;
        irq_id_d    = s2_q.id[IdW-1:0];
        irq_ctl_d   = s2_q.ctl[CtlWidth-1:0];
      end
      OFFER: if (irq_ready_i) begin
        state_d     = CLEAR;
        irq_valid_d = 1'b0;
        clr_valid_d = edge_i[irq_id_q];
        clr_id_d    = edge_i[irq_id_q] ? irq_id_q : clr_id_q;
      end else if (retract) begin
        state_d     = IDLE;
        irq_valid_d = 1'b0;
      end
      CLEAR: begin
        state_d = COOL;
        cool_d  = '0;
      end
      default: begin
        cool_d  = cool_q + 1'b1;
        state_d = (cool_q == CoolW'(CoolCycles - 1)) ? IDLE : COOL;
      end
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrGrp; i++) s1_q[i] <= '0;
      s2_q        <= '0;
      state_q     <= IDLE;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      irq_ctl_q   <= '0;
      clr_valid_q <= 1'b0;
      clr_id_q    <= '0;
      cool_q      <= '0;
      shv_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NrGrp; i++) s1_q[i] <= s1_d[i];
      s2_q        <= s2_d;
      state_q     <= state_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      irq_ctl_q   <= irq_ctl_d;
      clr_valid_q <= clr_valid_d;
      clr_id_q    <= clr_id_d;
      cool_q      <= cool_d;
      shv_q       <= shv_d;
    end
  end
  assign irq_valid_o = irq_valid_q;
  assign irq_id_o    = irq_id_q;
  assign irq_ctl_o   = irq_ctl_q;
  assign clr_valid_o = clr_valid_q;
  assign clr_id_o    = clr_id_q;
endmodule

// File: tb/tb_clic_irq_arbiter.sv
// tb_clic_irq_arbiter: directed self-checking bench for clic_irq_arbiter
module tb_clic_irq_arbiter;
  localparam int NrSrc = 64;
  localparam int CtlWidth = 8;
  localparam int IdW = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NrSrc-1:0] ip = '0, ie = '0, edg = '0;
  logic [NrSrc*CtlWidth-1:0] ctl = '0;
  logic [CtlWidth-1:0] thresh = '0;
  logic ready = 1'b0;
  logic irq_valid, clr_valid;
  logic [IdW-1:0] irq_id, clr_id;
  logic [CtlWidth-1:0] irq_ctl;
`ifdef CLIC_SHV_EN
  logic [NrSrc-1:0] shv = '0;
  logic irq_shv;
`endif
  int n_tests = 0;
  int n_fail = 0;
  clic_irq_arbiter #(.NrSrc(NrSrc), .CtlWidth(CtlWidth), .GroupSize(8), .CoolCycles(2)) dut (
    .clk_i(clk), .rst_i(rst), .ip_i(ip), .ie_i(ie), .edge_i(edg), .ctl_i(ctl),
    .thresh_i(thresh), .irq_valid_o(irq_valid), .irq_ready_i(ready), .irq_id_o(irq_id),
    .irq_ctl_o(irq_ctl), .clr_valid_o(clr_valid), .clr_id_o(clr_id)
`ifdef CLIC_SHV_EN
    , .shv_i(shv), .irq_shv_o(irq_shv)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic src(input int id, input logic [7:0] c, input logic e);
    ip[id] = 1'b1;
    ie[id] = 1'b1;
    ctl[id*CtlWidth +: CtlWidth] = c;
    edg[id] = e;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic restart();
    rst = 1'b1;
    ip = '0; ie = '0; edg = '0; ctl = '0; thresh = '0; ready = 1'b0;
`ifdef CLIC_SHV_EN
    shv = '0;
`endif
    cyc(2);
    rst = 1'b0;
  endtask
  initial begin
    cyc(1);
    check("rst_valid", 32'(irq_valid), 0);
    check("rst_id", 32'(irq_id), 0);
    check("rst_ctl", 32'(irq_ctl), 0);
    check("rst_clr", 32'(clr_valid), 0);
    check("rst_clr_id", 32'(clr_id), 0);
    rst = 1'b0;
    // basic offer, latency, claim of a level source, cooldown and re-offer, retraction
    src(5, 8'h40, 1'b0);
    cyc(2);
    check("lat2_valid", 32'(irq_valid), 0);
    cyc(1);
    check("basic_valid", 32'(irq_valid), 1);
    check("basic_id", 32'(irq_id), 5);
    check("basic_ctl", 32'(irq_ctl), 32'h40);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    check("claim_valid", 32'(irq_valid), 0);
    check("lvl_noclr", 32'(clr_valid), 0);
    cyc(3);
    check("cool_valid", 32'(irq_valid), 0);
    check("cool_hold_id", 32'(irq_id), 5);
    cyc(1);
    check("reoffer_valid", 32'(irq_valid), 1);
    check("reoffer_id", 32'(irq_id), 5);
    ip[5] = 1'b0;
    cyc(1);
    check("retract_ip", 32'(irq_valid), 0);
    check("retract_noclr", 32'(clr_valid), 0);
    // tie on ctl, disabled source ignored, no preemption while offering
    restart();
    src(3, 8'h80, 1'b0);
    src(9, 8'h80, 1'b0);
    ip[20] = 1'b1;
    ctl[20*CtlWidth +: CtlWidth] = 8'hFF;
    cyc(3);
    check("tie_valid", 32'(irq_valid), 1);
    check("tie_id", 32'(irq_id), 9);
    check("tie_ctl", 32'(irq_ctl), 32'h80);
    src(12, 8'hFF, 1'b0);
    cyc(4);
    check("stable_valid", 32'(irq_valid), 1);
    check("stable_id", 32'(irq_id), 9);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    check("stable_claim", 32'(irq_valid), 0);
    cyc(4);
    check("next_valid", 32'(irq_valid), 1);
    check("next_id", 32'(irq_id), 12);
    check("next_ctl", 32'(irq_ctl), 32'hFF);
    // higher ctl beats higher id
    restart();
    src(3, 8'h80, 1'b0);
    src(9, 8'h80, 1'b0);
    src(2, 8'h81, 1'b0);
    cyc(3);
    check("rank_id", 32'(irq_id), 2);
    check("rank_ctl", 32'(irq_ctl), 32'h81);
    // threshold is a strict compare; raising it retracts the offer
    restart();
    src(9, 8'h80, 1'b0);
    thresh = 8'h7F;
    cyc(3);
    check("thr_strict_valid", 32'(irq_valid), 1);
    check("thr_strict_id", 32'(irq_id), 9);
    thresh = 8'h80;
    cyc(1);
    check("thr_retract", 32'(irq_valid), 0);
    check("thr_noclr", 32'(clr_valid), 0);
    cyc(5);
    check("thr_block", 32'(irq_valid), 0);
    // top source with all-ones ctl wins; all-ones threshold blocks everything
    restart();
    src(62, 8'hFF, 1'b0);
    src(63, 8'hFF, 1'b0);
    thresh = 8'hFE;
    cyc(3);
    check("max_id", 32'(irq_id), 63);
    check("max_ctl", 32'(irq_ctl), 32'hFF);
    thresh = 8'hFF;
    cyc(6);
    check("thr_all_ones", 32'(irq_valid), 0);
    // edge source claim emits exactly one clear strobe; level source does not
    restart();
    src(7, 8'h10, 1'b1);
    src(6, 8'h10, 1'b0);
`ifdef CLIC_SHV_EN
    shv[7] = 1'b1;
`endif
    cyc(3);
    check("edge_valid", 32'(irq_valid), 1);
    check("edge_id", 32'(irq_id), 7);
`ifdef CLIC_SHV_EN
    check("edge_shv", 32'(irq_shv), 1);
`endif
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    ip[7] = 1'b0;
    check("clr_valid", 32'(clr_valid), 1);
    check("clr_id", 32'(clr_id), 7);
    check("clr_irq_valid", 32'(irq_valid), 0);
    cyc(1);
    check("clr_one_cycle", 32'(clr_valid), 0);
    cyc(3);
    check("lvl_valid", 32'(irq_valid), 1);
    check("lvl_id", 32'(irq_id), 6);
`ifdef CLIC_SHV_EN
    check("lvl_shv", 32'(irq_shv), 0);
`endif
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    check("lvl_noclr2", 32'(clr_valid), 0);
    check("lvl_clr_id_hold", 32'(clr_id), 7);
    // asynchronous reset while offering
    cyc(4);
    check("pre_rst_valid", 32'(irq_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(irq_valid), 0);
    check("async_rst_id", 32'(irq_id), 0);
    check("async_rst_clr", 32'(clr_valid), 0);
    ip = '0;
    cyc(1);
    rst = 1'b0;
    // ready with nothing offered is ignored
    ready = 1'b1;
    cyc(3);
    check("idle_ready_valid", 32'(irq_valid), 0);
    check("idle_ready_clr", 32'(clr_valid), 0);
    ready = 1'b0;
    src(40, 8'h22, 1'b1);
    cyc(3);
    check("after_idle_valid", 32'(irq_valid), 1);
    check("after_idle_id", 32'(irq_id), 40);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
